// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit/receive state encoding, word-length codes
// and the default baud oversampling ratio.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  localparam int OVERSAMPLE_DEF = 16;

endpackage

// File: rtl/uart_tx_engine_if.sv
// Pop-side handshake between the transmit serializer and the TX FIFO.
interface uart_tx_engine_if;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       pop;

  modport master (input fifo_empty, input fifo_dout, output pop);
  modport slave  (output fifo_empty, output fifo_dout, input pop);
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops one FIFO word per frame and shifts it out as
// start / 5-8 data bits LSB first / optional parity / 1, 1.5 or 2 stop bits.
//   state  | meaning
//   IDLE   | line high, waiting for baud tick with en and a word available
//   START  | start bit (low)
//   DATA   | data bits, shift register moves right after each bit
//   PARITY | precomputed parity bit
//   STOP   | stop period; may chain directly into the next START
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     baud_pulse,
  input  logic [1:0]               wls,
  input  logic                     stb,
  input  logic                     pen,
  input  logic                     eps,
  input  logic                     sp,
  input  logic                     bc,
  uart_tx_engine_if.master         fifo,
  output logic                     tx,
  output logic                     busy
);

  localparam int TW = $clog2(2 * OVERSAMPLE);

  tx_state_t     state_q, state_d;
  logic [TW-1:0] tick_q, tick_d, tick_last;
  logic [2:0]    bit_q, bit_d, bit_last;
  logic [7:0]    shift_q, shift_d, wmask;
  logic [1:0]    wls_q, wls_d;
  logic          stb_q, stb_d, pen_q, pen_d, par_q, par_d;
  logic          tx_q, tx_d, busy_q, busy_d;
  logic          bit_end, load, line_d, word_xor;

  always_comb begin
    wmask = 8'h1F;
    case (wls)
      WLS_6:   wmask = 8'h3F;
      WLS_7:   wmask = 8'h7F;
      WLS_8:   wmask = 8'hFF;
      default: wmask = 8'h1F;
    endcase
  end

  assign word_xor = ^(fifo.fifo_dout & wmask);
  assign bit_last = 3'd4 + {1'b0, wls_q};

  // The stop period is the only bit whose length depends on configuration.
  always_comb begin
    tick_last = TW'(OVERSAMPLE - 1);
    if (state_q == STOP && stb_q) begin
      if (wls_q == WLS_5) tick_last = TW'((3 * OVERSAMPLE) / 2 - 1);
      else                tick_last = TW'(2 * OVERSAMPLE - 1);
    end
  end

  assign bit_end = baud_pulse && (tick_q == tick_last);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    wls_d   = wls_q;
    stb_d   = stb_q;
    pen_d   = pen_q;
    par_d   = par_q;
    busy_d  = busy_q;
    load    = 1'b0;
    line_d  = 1'b1;

    if (baud_pulse && state_q != IDLE && !bit_end) tick_d = tick_q + TW'(1);

    case (state_q)
      IDLE: begin
        if (baud_pulse && en && !fifo.fifo_empty) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tick_d  = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          tick_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == bit_last) state_d = pen_q ? PARITY : STOP;
          else                   bit_d   = bit_q + 3'd1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tick_d  = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          tick_d = '0;
          if (en && !fifo.fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Parity is resolved at pop time so eps/sp need not be held separately.
    if (load) begin
      state_d = START;
      tick_d  = '0;
      busy_d  = 1'b1;
      shift_d = fifo.fifo_dout;
      wls_d   = wls;
      stb_d   = stb;
      pen_d   = pen;
      par_d   = sp ? ~eps : (eps ? word_xor : ~word_xor);
    end

    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
      PARITY:  line_d = par_d;
      default: line_d = 1'b1;
    endcase
    tx_d = bc ? 1'b0 : line_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wls_q   <= '0;
      stb_q   <= 1'b0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wls_q   <= wls_d;
      stb_q   <= stb_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign fifo.pop = load;
  assign tx       = tx_q;
  assign busy     = busy_q;

endmodule
